seg_scan_mux: RTL and testbench

Parametrised multiplexed seven-segment display driver: scans `NUM_DIGITS` hex digits onto one shared active-low segment bus with active-low one-hot digit selects. Over a plain 4-digit scanner it adds:
- a refresh prescaler and frame-coherent double-buffered loading;
- per-digit enable and decimal point;
- PWM brightness and an anti-ghosting guard cycle.

It sits between the datapath debug/status registers and the board display pins.

---
 rtl/seg_pkg.sv | 27 ++
 rtl/seg_hex_decode.sv | 12 +
 rtl/seg_scan_mux.sv | 161 ++++++++++++++++
 tb/tb_seg_scan_mux.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: glyph table, segment bit positions,
// and a helper that builds an active-low segment byte from a nibble and a decimal point.
package seg_pkg;

    localparam int unsigned SEG_A  = 7;
    localparam int unsigned SEG_G  = 1;
    localparam int unsigned SEG_DP = 0;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low, bit order a..g,dp; the dp bit is replaced by the caller's decimal point.
    localparam logic [7:0] GLYPH [16] = '{
        8'b0000_0011, 8'b1001_1111, 8'b0010_0101, 8'b0000_1101,
        8'b1001_1001, 8'b0100_1001, 8'b0100_0001, 8'b0001_1111,
        8'b0000_0001, 8'b0000_1001, 8'b0001_0001, 8'b1100_0001,
        8'b0110_0011, 8'b1000_0101, 8'b0110_0001, 8'b0111_0001
    };

    function automatic logic [7:0] seg_encode(input logic [3:0] nib, input logic dp);
        logic [7:0] s;
        s               = SEG_OFF;
        s[SEG_A:SEG_G]  = GLYPH[nib][SEG_A:SEG_G];
        s[SEG_DP]       = ~dp;
        return s;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble + decimal point to active-low segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    assign o_seg = seg_encode(i_nibble, i_dp);

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner with prescaler, frame-coherent double buffering,
// per-digit enable/dp, PWM brightness and a ghost-guard cycle.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned BRIGHT_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic [BRIGHT_W-1:0]     bright_i,
    input  logic                    load_i,
    output logic [7:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   sel_o,
    output logic                    frame_o
);

    localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PreW-1:0]     PreMax = PreW'(SCAN_DIV - 1);
    localparam logic [IdxW-1:0]     IdxMax = IdxW'(NUM_DIGITS - 1);
    localparam logic [BRIGHT_W-1:0] PwmMax = BRIGHT_W'((1 << BRIGHT_W) - 2);

    logic [PreW-1:0]         r_pre;
    logic [IdxW-1:0]         r_idx;
    logic [BRIGHT_W-1:0]     r_pwm;
    logic                    r_pending;

    logic [4*NUM_DIGITS-1:0] r_sh_digits;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_en;
    logic [BRIGHT_W-1:0]     r_sh_bright;

    logic [4*NUM_DIGITS-1:0] r_disp_digits;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [NUM_DIGITS-1:0]   r_disp_en;
    logic [BRIGHT_W-1:0]     r_disp_bright;

    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_sel;
    logic                    r_frame;

    logic                    w_pre_wrap;
    logic                    w_boundary;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [3:0]              w_nibble;
    logic                    w_dp;
    logic [7:0]              w_dec_seg;
    logic                    w_show;
    logic                    w_lit;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [7:0]              w_seg_next;
    logic [NUM_DIGITS-1:0]   w_sel_next;
    logic                    w_frame_next;

    assign w_pre_wrap = (r_pre == PreMax);
    assign w_boundary = w_pre_wrap && (r_idx == IdxMax);

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; the first nonzero nibble or lit dp ends blanking.
    always_comb begin
        logic run;
        w_blank = '0;
        run     = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            if (run && (r_disp_digits[4*k +: 4] == 4'h0) && !r_disp_dp[k]) begin
                w_blank[k] = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end
`else
    assign w_blank = '0;
`endif

    assign w_nibble = r_disp_digits[r_idx*4 +: 4];
    assign w_dp     = r_disp_dp[r_idx];

    seg_hex_decode u_dec (
        .i_nibble (w_nibble),
        .i_dp     (w_dp),
        .o_seg    (w_dec_seg)
    );

    assign w_show   = r_disp_en[r_idx] && !w_blank[r_idx];
    assign w_lit    = (r_disp_bright == '1) || (r_pwm < r_disp_bright);
    assign w_onehot = NUM_DIGITS'(1) << r_idx;

    always_comb begin
        w_seg_next   = w_show ? w_dec_seg : SEG_OFF;
        w_sel_next   = '1;
        // pre == 0 is the guard slot that lets the previous digit's drivers discharge.
        if (w_show && w_lit && (r_pre != '0)) begin
            w_sel_next = ~w_onehot;
        end
        w_frame_next = (r_idx == '0) && (r_pre == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre         <= '0;
            r_idx         <= '0;
            r_pwm         <= '0;
            r_pending     <= 1'b0;
            r_sh_digits   <= '0;
            r_sh_dp       <= '0;
            r_sh_en       <= '0;
            r_sh_bright   <= '0;
            r_disp_digits <= '0;
            r_disp_dp     <= '0;
            r_disp_en     <= '0;
            r_disp_bright <= '0;
            r_seg         <= SEG_OFF;
            r_sel         <= '1;
            r_frame       <= 1'b0;
        end else begin
            r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
            if (w_pre_wrap) begin
                r_idx <= (r_idx == IdxMax) ? '0 : r_idx + 1'b1;
            end
            r_pwm <= (r_pwm == PwmMax) ? '0 : r_pwm + 1'b1;

            if (load_i) begin
                r_sh_digits <= digits_i;
                r_sh_dp     <= dp_i;
                r_sh_en     <= digit_en_i;
                r_sh_bright <= bright_i;
            end

            // A load on the boundary cycle still transfers the prior shadow contents.
            if (w_boundary && r_pending) begin
                r_disp_digits <= r_sh_digits;
                r_disp_dp     <= r_sh_dp;
                r_disp_en     <= r_sh_en;
                r_disp_bright <= r_sh_bright;
            end

            if (load_i) begin
                r_pending <= 1'b1;
            end else if (w_boundary) begin
                r_pending <= 1'b0;
            end

            r_seg   <= w_seg_next;
            r_sel   <= w_sel_next;
            r_frame <= w_frame_next;
        end
    end

    assign seg_o   = r_seg;
    assign sel_o   = r_sel;
    assign frame_o = r_frame;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux (4 digits, 4-cycle slots, 2-bit brightness).
module tb_seg_scan_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_i;
    logic [3:0]  dp_i;
    logic [3:0]  digit_en_i;
    logic [1:0]  bright_i;
    logic        load_i;
    logic [7:0]  seg_o;
    logic [3:0]  sel_o;
    logic        frame_o;

    int errors = 0;
    int checks = 0;
    int ncyc;

    seg_scan_mux #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .BRIGHT_W   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_i   (digits_i),
        .dp_i       (dp_i),
        .digit_en_i (digit_en_i),
        .bright_i   (bright_i),
        .load_i     (load_i),
        .seg_o      (seg_o),
        .sel_o      (sel_o),
        .frame_o    (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges since reset release; the sample after edge n reflects the state after n-1 edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    typedef struct {
        string       name;
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [1:0]  bright;
        logic [31:0] segs;  // expected seg byte per digit {d3,d2,d1,d0}; FF = not shown
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input string nm, input logic [15:0] d, input logic [3:0] dp,
                                input logic [3:0] en, input logic [1:0] br,
                                input logic [31:0] segs);
        vec_t v;
        v.name = nm; v.digits = d; v.dp = dp; v.en = en; v.bright = br; v.segs = segs;
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        load_i     = 1'b0;
        digits_i   = 16'hEEEE;
        dp_i       = 4'hF;
        digit_en_i = 4'h0;
        bright_i   = 2'd0;
    endtask

    task automatic set_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                            input logic [1:0] br);
        digits_i   = d;
        dp_i       = dp;
        digit_en_i = en;
        bright_i   = br;
        load_i     = 1'b1;
    endtask

    task automatic check_now(input logic [31:0] segs, input logic [1:0] br, input string nm);
        int         t, pre, idx, pwm;
        logic       show, lit;
        logic [3:0] esel;
        logic [7:0] eseg;
        t    = ncyc - 1;
        pre  = t % 4;
        idx  = (t / 4) % 4;
        pwm  = t % 3;
        eseg = segs[idx*8 +: 8];
        show = (eseg != 8'hFF);
        lit  = (br == 2'd3) || (pwm < int'(br));
        esel = (show && lit && pre != 0) ? ~(4'b0001 << idx) : 4'hF;
        chk({nm, "_sel"}, 32'(sel_o), 32'(esel));
        if (esel != 4'hF || !show) chk({nm, "_seg"}, 32'(seg_o), 32'(eseg));
        chk({nm, "_frame"}, 32'(frame_o), 32'((t % 16) == 0));
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_o !== 1'b1 && n < 40);
        chk("frame_timeout", 32'(frame_o), 32'd1);
    endtask

    task automatic run_vector(input vec_t v);
        idle_inputs();
        wait_frame();
        set_load(v.digits, v.dp, v.en, v.bright);
        tick();
        idle_inputs();
        wait_frame();
        for (int c = 0; c < 16; c++) begin
            check_now(v.segs, v.bright, v.name);
            tick();
        end
    endtask

    localparam logic [31:0] SegsOld  = 32'h99_0D_25_9F;
    localparam logic [31:0] SegsAbcd = 32'h11_C1_63_85;
    localparam logic [31:0] Segs7777 = 32'h1F_1F_1F_1F;
    localparam logic [31:0] Segs9999 = 32'h09_09_09_09;
    localparam logic [31:0] SegsDark = 32'hFF_FF_FF_FF;

    initial begin
        vecs[0] = mk("scan",       16'h4321, 4'b0001, 4'hF, 2'd3, 32'h99_0D_25_9E);
        vecs[1] = mk("partial_en", 16'h8765, 4'b1010, 4'b0101, 2'd3, 32'hFF_1F_FF_49);
        vecs[2] = mk("dark",       16'h4321, 4'b0000, 4'hF, 2'd0, SegsOld);
        vecs[3] = mk("pwm1",       16'h4321, 4'b0000, 4'hF, 2'd1, SegsOld);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        vecs[4] = mk("lzb_a5",     16'h00A5, 4'b0000, 4'hF, 2'd3, 32'hFF_FF_11_49);
        vecs[5] = mk("lzb_zero",   16'h0000, 4'b0000, 4'hF, 2'd3, 32'hFF_FF_FF_03);
        vecs[6] = mk("lzb_dp",     16'h0000, 4'b0100, 4'hF, 2'd3, 32'hFF_02_03_03);
`else
        vecs[4] = mk("lzb_a5",     16'h00A5, 4'b0000, 4'hF, 2'd3, 32'h03_03_11_49);
        vecs[5] = mk("lzb_zero",   16'h0000, 4'b0000, 4'hF, 2'd3, 32'h03_03_03_03);
        vecs[6] = mk("lzb_dp",     16'h0000, 4'b0100, 4'hF, 2'd3, 32'h03_02_03_03);
`endif
        vecs[7] = mk("pwm2",       16'h4321, 4'b0000, 4'hF, 2'd2, SegsOld);

        rst_n = 1'b0;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_sel", 32'(sel_o), 32'hF);
            chk("rst_seg", 32'(seg_o), 32'hFF);
            chk("rst_frame", 32'(frame_o), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            check_now(SegsDark, 2'd3, "preload");
        end

        foreach (vecs[i]) run_vector(vecs[i]);

        // Mid-frame load during digit 1: old data holds to the end of the frame.
        wait_frame();
        for (int c = 0; c < 16; c++) begin
            check_now(SegsOld, 2'd2, "midload_old");
            if (c == 5) set_load(16'hABCD, 4'b0000, 4'hF, 2'd3);
            else        idle_inputs();
            tick();
        end
        // Load 7777 mid-frame, then 9999 on the boundary cycle itself.
        for (int c = 0; c < 16; c++) begin
            check_now(SegsAbcd, 2'd3, "midload_new");
            if (c == 5)       set_load(16'h7777, 4'b0000, 4'hF, 2'd3);
            else if (c == 14) set_load(16'h9999, 4'b0000, 4'hF, 2'd3);
            else              idle_inputs();
            tick();
        end
        for (int c = 0; c < 16; c++) begin
            check_now(Segs7777, 2'd3, "bnd_prior");
            tick();
        end
        for (int c = 0; c < 9; c++) begin
            check_now(Segs9999, 2'd3, "bnd_next");
            tick();
        end
        check_now(Segs9999, 2'd3, "pre_reset");

        // Asynchronous reset while digit 2 is being driven.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sel", 32'(sel_o), 32'hF);
        chk("async_rst_seg", 32'(seg_o), 32'hFF);
        chk("async_rst_frame", 32'(frame_o), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check_now(SegsDark, 2'd3, "post_reset");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
